pwm_fade_scheduler: RTL and testbench

- Sequences the per-channel fill words of the multichannel PWM generator, so LED brightness ramps to commanded targets.
- Accepts fade commands (channel, target, step) over a valid/ready handshake.
- A free-running prescaler produces a tick. On each tick a round-robin scan visits every channel once and moves its fill one step toward its target.
- Output `fill` connects directly to the PWM controller's packed fill input.

---
 rtl/pwm_fade_scheduler.sv | 140 ++++++++++++++
 tb/tb_pwm_fade_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pwm_fade_scheduler
// Description : Ramps per-channel PWM fill words toward commanded targets,
//               one round-robin scan per prescaler tick.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_fade_scheduler #(
    parameter int CHANNELS   = 3,
    parameter int RESOLUTION = 8,
    parameter int LOG2DELAY  = 18,
    parameter int CH_BITS    = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [CH_BITS-1:0]             cmd_channel,
    input  logic [RESOLUTION-1:0]          cmd_target,
    input  logic [RESOLUTION-1:0]          cmd_step,
    output logic [CHANNELS*RESOLUTION-1:0] fill,
    output logic [CHANNELS-1:0]            busy,
    output logic [CHANNELS-1:0]            done,
    output logic                           cmd_err
);

    localparam logic [0:0]         IDLE     = 1'b0;
    localparam logic [0:0]         SCAN     = 1'b1;
    localparam logic [CH_BITS-1:0] LAST_IDX = CH_BITS'(CHANNELS - 1);
    localparam logic [CH_BITS:0]   CH_LIMIT = (CH_BITS + 1)'(CHANNELS);

    logic [LOG2DELAY-1:0]  prescale;
    logic                  tick;
    logic [0:0]            state;
    logic [CH_BITS-1:0]    idx;
    logic [RESOLUTION-1:0] fill_q   [CHANNELS];
    logic [RESOLUTION-1:0] target_q [CHANNELS];
    logic [RESOLUTION-1:0] step_q   [CHANNELS];

    logic                  cmd_ok;
    logic [RESOLUTION-1:0] cur_fill;
    logic [RESOLUTION-1:0] cur_target;
    logic [RESOLUTION-1:0] cur_step;
    logic                  moving_up;
    logic [RESOLUTION:0]   distance;
    logic [RESOLUTION-1:0] next_fill;

    assign tick      = &prescale;
    assign cmd_ready = (state == IDLE);
    assign cmd_ok    = ({1'b0, cmd_channel} < CH_LIMIT);

    // Operands of the channel currently visited by the scan
    always_comb begin
        cur_fill   = '0;
        cur_target = '0;
        cur_step   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx == CH_BITS'(i)) begin
                cur_fill   = fill_q[i];
                cur_target = target_q[i];
                cur_step   = step_q[i];
            end
        end
    end

    // One extra bit keeps the distance exact so a final short step saturates
    always_comb begin
        moving_up = (cur_target > cur_fill);
        distance  = moving_up ? ({1'b0, cur_target} - {1'b0, cur_fill})
                              : ({1'b0, cur_fill} - {1'b0, cur_target});
        if ((cur_step == '0) || (distance <= {1'b0, cur_step})) begin
            next_fill = cur_target;
        end else if (moving_up) begin
            next_fill = cur_fill + cur_step;
        end else begin
            next_fill = cur_fill - cur_step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale <= '0;
            state    <= IDLE;
            idx      <= '0;
            done     <= '0;
            cmd_err  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                fill_q[i]   <= '0;
                target_q[i] <= '0;
                step_q[i]   <= RESOLUTION'(1);
            end
        end else begin
            prescale <= prescale + 1'b1;
            done     <= '0;
            cmd_err  <= 1'b0;
            if (state == IDLE) begin
                if (cmd_valid) begin
                    if (cmd_ok) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            if (cmd_channel == CH_BITS'(i)) begin
                                target_q[i] <= cmd_target;
                                step_q[i]   <= cmd_step;
                            end
                        end
                    end else begin
                        cmd_err <= 1'b1;
                    end
                end
                if (tick) begin
                    state <= SCAN;
                    idx   <= '0;
                end
            end else begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (idx == CH_BITS'(i)) begin
                        fill_q[i] <= next_fill;
                        if ((cur_fill != cur_target) && (next_fill == cur_target)) begin
                            done[i] <= 1'b1;
                        end
                    end
                end
                if (idx == LAST_IDX) begin
                    state <= IDLE;
                    idx   <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
            assign fill[(g+1)*RESOLUTION-1 -: RESOLUTION] = fill_q[g];
            assign busy[g] = (fill_q[g] != target_q[g]);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_fade_scheduler
// Description : Directed, table-driven self-checking bench (3 ch, tick/16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_fade_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_channel = '0;
    logic [7:0]  cmd_target = '0;
    logic [7:0]  cmd_step = '0;
    logic [23:0] fill;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic        cmd_err;

    int checks = 0;
    int errors = 0;
    int done_cnt [3];

    pwm_fade_scheduler #(
        .CHANNELS   (3),
        .RESOLUTION (8),
        .LOG2DELAY  (4),
        .CH_BITS    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_channel (cmd_channel),
        .cmd_target  (cmd_target),
        .cmd_step    (cmd_step),
        .fill        (fill),
        .busy        (busy),
        .done        (done),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  ch;
        logic [7:0]  tgt;
        logic [7:0]  stp;
        int          scans;
        logic [23:0] exp_fill;
        logic [2:0]  exp_busy;
        logic [2:0]  exp_done;
        logic        exp_err;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) if (done[i] === 1'b1) done_cnt[i]++;
    endtask

    task automatic clear_done();
        for (int i = 0; i < 3; i++) done_cnt[i] = 0;
    endtask

    task automatic send(input logic [1:0] ch, input logic [7:0] tgt, input logic [7:0] stp);
        cmd_channel = ch;
        cmd_target  = tgt;
        cmd_step    = stp;
        cmd_valid   = 1'b1;
        step();
        cmd_valid   = 1'b0;
    endtask

    // Waits for the next scan to start and finish; ends in the first IDLE cycle
    task automatic run_scan();
        int n;
        n = 0;
        while (cmd_ready !== 1'b0 && n < 40) begin step(); n++; end
        if (cmd_ready !== 1'b0) chk("scan_start_timeout", 32'(cmd_ready), 32'd0);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 10) begin step(); n++; end
        if (cmd_ready !== 1'b1) chk("scan_end_timeout", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int low;
        tbl[0] = '{1'b1, 2'd0, 8'd255, 8'd0,   1, 24'h0064FF, 3'b000, 3'b001, 1'b0};
        tbl[1] = '{1'b1, 2'd0, 8'd5,   8'd100, 1, 24'h00649B, 3'b001, 3'b000, 1'b0};
        tbl[2] = '{1'b0, 2'd0, 8'd0,   8'd0,   1, 24'h006437, 3'b001, 3'b000, 1'b0};
        tbl[3] = '{1'b0, 2'd0, 8'd0,   8'd0,   1, 24'h006405, 3'b000, 3'b001, 1'b0};
        tbl[4] = '{1'b1, 2'd3, 8'd77,  8'd1,   1, 24'h006405, 3'b000, 3'b000, 1'b1};
        tbl[5] = '{1'b1, 2'd2, 8'd200, 8'd8,   8, 24'h406405, 3'b100, 3'b000, 1'b0};
        tbl[6] = '{1'b1, 2'd2, 8'd40,  8'd8,   3, 24'h286405, 3'b000, 3'b100, 1'b0};
        clear_done();

        // Reset state and first tick position
        step(); step();
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(cmd_err), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("tick_not_before_15", 32'(cmd_ready), 32'd1);
        step();
        chk("tick_at_15", 32'(cmd_ready), 32'd0);
        run_scan();

        // Upward fade on ch1
        clear_done();
        send(2'd1, 8'd100, 8'd10);
        for (int s = 1; s <= 10; s++) begin
            run_scan();
            chk("up_fill", 32'(fill), 32'({8'd0, 8'(10 * s), 8'd0}));
            chk("up_busy", 32'(busy), (s == 10) ? 32'd0 : 32'd2);
        end
        step();
        chk("up_done_count", 32'(done_cnt[1]), 32'd1);
        chk("up_done_other", 32'(done_cnt[0] + done_cnt[2]), 32'd0);
        run_scan();

        // Table-driven vectors
        for (int v = 0; v < 7; v++) begin
            clear_done();
            if (tbl[v].valid) begin
                send(tbl[v].ch, tbl[v].tgt, tbl[v].stp);
                chk("err_pulse", 32'(cmd_err), 32'(tbl[v].exp_err));
                step();
                chk("err_clear", 32'(cmd_err), 32'd0);
            end
            for (int s = 0; s < tbl[v].scans; s++) run_scan();
            chk("vec_fill", 32'(fill), 32'(tbl[v].exp_fill));
            chk("vec_busy", 32'(busy), 32'(tbl[v].exp_busy));
            for (int i = 0; i < 3; i++)
                chk("vec_done", 32'(done_cnt[i]), 32'(tbl[v].exp_done[i]));
        end

        // Command in the tick cycle, then a command held through a scan
        for (int i = 0; i < 12; i++) step();
        chk("tick_cycle_ready", 32'(cmd_ready), 32'd1);
        send(2'd1, 8'd90, 8'd0);
        chk("tick_taken", 32'(cmd_ready), 32'd0);
        cmd_channel = 2'd2;
        cmd_target  = 8'd0;
        cmd_step    = 8'd0;
        cmd_valid   = 1'b1;
        low = 1;
        for (int n = 0; n < 10 && cmd_ready !== 1'b1; n++) begin
            step();
            if (cmd_ready === 1'b0) low++;
        end
        chk("ready_low_cycles", 32'(low), 32'd3);
        chk("same_tick_fill", 32'(fill), 32'h285A05);
        step();
        cmd_valid = 1'b0;
        chk("held_accept_busy", 32'(busy), 32'd4);
        run_scan();
        chk("held_fill", 32'(fill), 32'h005A05);
        chk("held_busy", 32'(busy), 32'd0);

        // Reset in the middle of a scan
        send(2'd0, 8'd200, 8'd50);
        low = 0;
        while (cmd_ready !== 1'b0 && low < 40) begin step(); low++; end
        step();
        chk("midscan_fill", 32'(fill), 32'h005A37);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_fill", 32'(fill), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("re_tick_not_before_15", 32'(cmd_ready), 32'd1);
        step();
        chk("re_tick_at_15", 32'(cmd_ready), 32'd0);
        chk("re_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
